// File: rtl/elevator_pkg.sv
// Codes shared by the elevator call register and the elevator controller.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;

  typedef enum logic [1:0] {
    f0 = 2'b00,
    f1 = 2'b01,
    f2 = 2'b10,
    f3 = 2'b11
  } floor_e;

  typedef enum logic [1:0] {
    dir_none  = 2'b00,
    move_up   = 2'b01,
    move_down = 2'b10,
    stop      = 2'b11
  } dir_e;

  typedef enum logic {
    door_close = 1'b0,
    door_open  = 1'b1
  } door_e;

  // Population count of the three 4-bit pending bitmaps (max 12 fits in 4 bits).
  function automatic logic [3:0] count_pending(input logic [3*NUM_FLOORS-1:0] bits);
    logic [3:0] acc;
    acc = '0;
    for (int i = 0; i < 3 * NUM_FLOORS; i++) begin
      acc = acc + {3'b000, bits[i]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/elevator_call_register_button_debounce.sv
// One button path: 2-flop synchroniser, stability counter, accepted level and a registered rise pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_reg;
  logic       sync2_reg;
  logic       db_reg;
  logic       rise_reg;
  logic [7:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      db_reg    <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2_reg != db_reg) begin
        if (cnt_reg == CNT_LAST) begin
          db_reg   <= sync2_reg;
          cnt_reg  <= '0;
          rise_reg <= sync2_reg;
        end else begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/elevator_call_register.sv
// Captures debounced hall and car button presses as pending request bits, cleared by controller serve strobes.
module elevator_call_register
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] move_up_call,
  input  logic [3:0] move_down_call,
  input  logic [3:0] req_floor,
  input  logic       serve_valid,
  input  logic [1:0] serve_floor,
  input  logic [1:0] serve_dir,
  output logic [3:0] up_pending,
  output logic [3:0] down_pending,
  output logic [3:0] car_pending,
  output logic [3:0] req_count,
  output logic       any_req
);

  logic [NUM_FLOORS-1:0] up_rise;
  logic [NUM_FLOORS-1:0] down_rise;
  logic [NUM_FLOORS-1:0] car_rise;

  logic [NUM_FLOORS-1:0] clr_up;
  logic [NUM_FLOORS-1:0] clr_down;
  logic [NUM_FLOORS-1:0] clr_car;

  logic [NUM_FLOORS-1:0] up_pending_reg, up_pending_next;
  logic [NUM_FLOORS-1:0] down_pending_reg, down_pending_next;
  logic [NUM_FLOORS-1:0] car_pending_reg, car_pending_next;
  logic [3:0]            req_count_reg, req_count_next;
  logic                  any_req_reg;

  // No up call exists at the top floor and no down call at the bottom floor.
  logic unused_inputs;
  assign unused_inputs = move_up_call[NUM_FLOORS-1] ^ move_down_call[0];

  for (genvar gi = 0; gi < NUM_FLOORS - 1; gi++) begin : g_up
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (move_up_call[gi]),
      .rise (up_rise[gi])
    );
  end
  assign up_rise[NUM_FLOORS-1] = 1'b0;

  for (genvar gi = 1; gi < NUM_FLOORS; gi++) begin : g_down
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (move_down_call[gi]),
      .rise (down_rise[gi])
    );
  end
  assign down_rise[0] = 1'b0;

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_car
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (req_floor[gi]),
      .rise (car_rise[gi])
    );
  end

  // A stop (or the unused 00 code) serves both hall directions at the floor.
  always_comb begin
    clr_up   = '0;
    clr_down = '0;
    clr_car  = '0;
    if (serve_valid) begin
      clr_car[serve_floor] = 1'b1;
      case (dir_e'(serve_dir))
        move_up:   clr_up[serve_floor] = 1'b1;
        move_down: clr_down[serve_floor] = 1'b1;
        default: begin
          clr_up[serve_floor]   = 1'b1;
          clr_down[serve_floor] = 1'b1;
        end
      endcase
    end
  end

  // Rise is OR-ed after the clear so a press landing with a serve is kept.
  always_comb begin
    up_pending_next   = (up_pending_reg & ~clr_up) | up_rise;
    down_pending_next = (down_pending_reg & ~clr_down) | down_rise;
    car_pending_next  = (car_pending_reg & ~clr_car) | car_rise;
    req_count_next    = count_pending({up_pending_next, down_pending_next, car_pending_next});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_pending_reg   <= '0;
      down_pending_reg <= '0;
      car_pending_reg  <= '0;
      req_count_reg    <= '0;
      any_req_reg      <= 1'b0;
    end else begin
      up_pending_reg   <= up_pending_next;
      down_pending_reg <= down_pending_next;
      car_pending_reg  <= car_pending_next;
      req_count_reg    <= req_count_next;
      any_req_reg      <= (req_count_next != 4'd0);
    end
  end

  assign up_pending   = up_pending_reg;
  assign down_pending = down_pending_reg;
  assign car_pending  = car_pending_reg;
  assign req_count    = req_count_reg;
  assign any_req      = any_req_reg;

endmodule

// File: tb/tb_elevator_call_register.sv
// Table-driven and sequence tests of elevator_call_register, checked through a cycle-stamped scoreboard.
module tb_elevator_call_register;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] move_up_call = '0;
  logic [3:0] move_down_call = '0;
  logic [3:0] req_floor = '0;
  logic       serve_valid = 1'b0;
  logic [1:0] serve_floor = '0;
  logic [1:0] serve_dir = '0;
  logic [3:0] up_pending;
  logic [3:0] down_pending;
  logic [3:0] car_pending;
  logic [3:0] req_count;
  logic       any_req;

  elevator_call_register #(.DEBOUNCE_CYCLES(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .move_up_call   (move_up_call),
    .move_down_call (move_down_call),
    .req_floor      (req_floor),
    .serve_valid    (serve_valid),
    .serve_floor    (serve_floor),
    .serve_dir      (serve_dir),
    .up_pending     (up_pending),
    .down_pending   (down_pending),
    .car_pending    (car_pending),
    .req_count      (req_count),
    .any_req        (any_req)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [16:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  compared = 0;
  int  mismatched = 0;

  function automatic logic [16:0] pack(input logic [3:0] u, input logic [3:0] d, input logic [3:0] c);
    logic [3:0] n;
    n = 4'($countones({u, d, c}));
    return {u, d, c, n, (n != 4'd0)};
  endfunction

  task automatic expect_at(input int cyc, input string nm,
                           input logic [3:0] u, input logic [3:0] d, input logic [3:0] c);
    sb_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.exp  = pack(u, d, c);
    sb_q.push_back(e);
  endtask

  // Outputs are compared on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    sb_t         e;
    logic [16:0] act;
    act = {up_pending, down_pending, car_pending, req_count, any_req};
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      e = sb_q.pop_front();
      compared++;
      if (e.cyc != cyc_cnt) begin
        mismatched++;
        $display("FAIL %s: check missed, due cyc %0d now %0d", e.name, e.cyc, cyc_cnt);
      end else if (act !== e.exp) begin
        mismatched++;
        $display("FAIL %s cyc=%0d: got up=%b dn=%b car=%b cnt=%0d any=%b, want up=%b dn=%b car=%b cnt=%0d any=%b",
                 e.name, cyc_cnt, act[16:13], act[12:9], act[8:5], act[4:1], act[0],
                 e.exp[16:13], e.exp[12:9], e.exp[8:5], e.exp[4:1], e.exp[0]);
      end else begin
        $display("check %s cyc=%0d ok (cnt=%0d)", e.name, cyc_cnt, act[4:1]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    move_up_call = '0;
    move_down_call = '0;
    req_floor = '0;
    serve_valid = 1'b0;
    step(1);
    rst = 1'b0;
    expect_at(cyc_cnt, "reset", 4'b0, 4'b0, 4'b0);
  endtask

  typedef struct {
    logic [3:0] mu, md, rf;
    logic [1:0] sf, sd;
    logic [3:0] pu, pd, pc;
    logic [3:0] au, ad, ac;
  } vec_t;

  vec_t vec[6];

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int base2;

    //        mu       md       rf       sf     sd     press: up dn car           served: up dn car
    vec[0] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 2'b01, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vec[1] = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 2'b01, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    vec[2] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 2'b10, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    vec[3] = '{4'b1010, 4'b1001, 4'b1000, 2'd3, 2'b11, 4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b0000, 4'b0000};
    vec[4] = '{4'b0111, 4'b1110, 4'b1111, 2'd1, 2'b00, 4'b0111, 4'b1110, 4'b1111, 4'b0101, 4'b1100, 4'b1101};
    vec[5] = '{4'b0010, 4'b0000, 4'b0000, 2'd0, 2'b11, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};

    // Idle after reset: nothing ever pending.
    do_reset();
    base = cyc_cnt;
    for (int k = 1; k <= 10; k++) expect_at(base + 10 * k, "idle", 4'b0, 4'b0, 4'b0);
    step(100);

    // Table: press, release, then serve for two cycles (second cycle must be a no-op).
    for (int i = 0; i < 6; i++) begin
      do_reset();
      move_up_call = vec[i].mu;
      move_down_call = vec[i].md;
      req_floor = vec[i].rf;
      base = cyc_cnt;
      expect_at(base + D + 2, $sformatf("tbl%0d_early", i), 4'b0, 4'b0, 4'b0);
      expect_at(base + D + 3, $sformatf("tbl%0d_press", i), vec[i].pu, vec[i].pd, vec[i].pc);
      step(D + 3);
      move_up_call = '0;
      move_down_call = '0;
      req_floor = '0;
      step(2 * D + 4);
      serve_valid = 1'b1;
      serve_floor = vec[i].sf;
      serve_dir = vec[i].sd;
      base = cyc_cnt;
      expect_at(base + 1, $sformatf("tbl%0d_serve", i), vec[i].au, vec[i].ad, vec[i].ac);
      expect_at(base + 2, $sformatf("tbl%0d_serve2", i), vec[i].au, vec[i].ad, vec[i].ac);
      step(2);
      serve_valid = 1'b0;
      step(2);
    end

    // Held car button sets once, at edge D+3, and stays counted once.
    do_reset();
    req_floor = 4'b0100;
    base = cyc_cnt;
    expect_at(base + D + 2, "hold_early", 4'b0, 4'b0, 4'b0);
    expect_at(base + D + 3, "hold_set", 4'b0, 4'b0, 4'b0100);
    expect_at(base + D + 53, "hold_long", 4'b0, 4'b0, 4'b0100);
    step(D + 53);
    req_floor = '0;
    step(12);

    // Bounce restarts the count; a short pulse never sets.
    do_reset();
    move_up_call = 4'b0010;
    step(3);
    move_up_call = 4'b0000;
    step(1);
    move_up_call = 4'b0010;
    base2 = cyc_cnt;
    expect_at(base2 + D + 2, "bounce_early", 4'b0, 4'b0, 4'b0);
    expect_at(base2 + D + 3, "bounce_set", 4'b0010, 4'b0, 4'b0);
    step(10);
    move_up_call = 4'b0000;
    step(12);
    req_floor = 4'b0001;
    base = cyc_cnt;
    step(3);
    req_floor = 4'b0000;
    expect_at(base + 12, "glitch", 4'b0010, 4'b0, 4'b0);
    step(14);

    // Serve up at floor 0, then down at floor 2.
    do_reset();
    move_up_call = 4'b0001;
    move_down_call = 4'b0100;
    req_floor = 4'b0001;
    base = cyc_cnt;
    expect_at(base + D + 3, "srv_press", 4'b0001, 4'b0100, 4'b0001);
    step(D + 3);
    move_up_call = '0;
    move_down_call = '0;
    req_floor = '0;
    step(12);
    serve_valid = 1'b1;
    serve_floor = 2'd0;
    serve_dir = 2'b01;
    expect_at(cyc_cnt + 1, "srv_f0_up", 4'b0, 4'b0100, 4'b0);
    step(1);
    serve_valid = 1'b0;
    step(2);
    serve_valid = 1'b1;
    serve_floor = 2'd2;
    serve_dir = 2'b10;
    expect_at(cyc_cnt + 1, "srv_f2_dn", 4'b0, 4'b0, 4'b0);
    step(1);
    serve_valid = 1'b0;
    step(2);

    // Set and clear on the same bit in the same cycle: set wins.
    do_reset();
    move_down_call = 4'b1000;
    base = cyc_cnt;
    expect_at(base + D + 3, "conf_dn", 4'b0, 4'b1000, 4'b0);
    step(D + 3);
    move_down_call = '0;
    step(12);
    req_floor = 4'b1000;
    base = cyc_cnt;
    expect_at(base + D + 2, "conf_pre", 4'b0, 4'b1000, 4'b0);
    step(D + 2);
    serve_valid = 1'b1;
    serve_floor = 2'd3;
    serve_dir = 2'b11;
    expect_at(base + D + 3, "conf_set", 4'b0, 4'b0, 4'b1000);
    expect_at(base + D + 4, "conf_after", 4'b0, 4'b0, 4'b1000);
    step(1);
    serve_valid = 1'b0;
    req_floor = '0;
    step(12);

    // All ten buttons, partial serve, then reset in the middle of a re-press.
    do_reset();
    move_up_call = 4'b1111;
    move_down_call = 4'b1111;
    req_floor = 4'b1111;
    base = cyc_cnt;
    expect_at(base + D + 3, "all_ten", 4'b0111, 4'b1110, 4'b1111);
    step(D + 3);
    move_up_call = '0;
    move_down_call = '0;
    req_floor = '0;
    step(12);
    serve_valid = 1'b1;
    serve_floor = 2'd0;
    serve_dir = 2'b11;
    expect_at(cyc_cnt + 1, "all_srv_f0", 4'b0110, 4'b1110, 4'b1110);
    step(1);
    serve_valid = 1'b0;
    req_floor = 4'b0001;
    step(3);
    rst = 1'b1;
    req_floor = 4'b0000;
    step(1);
    rst = 1'b0;
    expect_at(cyc_cnt, "rst_mid", 4'b0, 4'b0, 4'b0);
    expect_at(cyc_cnt + 10, "rst_no_late", 4'b0, 4'b0, 4'b0);
    step(14);

    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard: %0d checks left unconsumed, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
